// File: rtl/wb_bcd_writer.sv
// wb_bcd_writer: Wishbone master for the seven-segment display peripheral.
// It accepts a binary value on a valid/ready handshake and saturates it to
// 99,999,999. It converts the value to 8 packed BCD digits by double dabble,
// one bit per cycle. It then issues a single 32-bit Wishbone write of the BCD
// word to address WB_ADR.
// Optional feature: define WB_BCD_TIMEOUT_EN to bound the wait for ack by
// TIMEOUT cycles. A timeout sets a sticky o_err. Without the macro, WRITE waits
// indefinitely and o_err is tied low.
module wb_bcd_writer #(
    parameter int          BIN_WIDTH = 27,
    parameter logic [31:0] WB_ADR    = 32'h0000_0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic                 i_wb_clk,
    input  logic                 i_wb_rst,
    input  logic [BIN_WIDTH-1:0] i_bin,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [31:0]          o_wb_adr,
    output logic [31:0]          o_wb_dat,
    output logic [3:0]           o_wb_sel,
    output logic                 o_wb_we,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    input  logic                 i_wb_ack,
    output logic                 o_done,
    output logic                 o_ovf,
    output logic                 o_err
);

    localparam int          CNT_W   = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
    localparam logic [63:0] DEC_MAX = 64'd99_999_999;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_WRITE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 w_accept;
    logic                 w_ack_ok;
    logic                 w_tmo;
    logic                 w_sat;
    logic [BIN_WIDTH-1:0] w_bin_sat;
    logic [31:0]          w_adj;
    logic                 w_wr;

    logic [BIN_WIDTH-1:0] r_bin;
    logic [31:0]          r_bcd;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_ovf_flag;
    logic                 r_done;
    logic                 r_ovf_pulse;

`ifdef WB_BCD_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TMO_W-1:0] r_wait;
    logic             r_err;
`endif

    // Add 3 to every nibble that is 5 or more, so the next shift carries correctly into the next digit.
    function automatic logic [31:0] bcd_adjust(input logic [31:0] v);
        logic [31:0] r;
        r = v;
        for (int i = 0; i < 8; i++) begin
            if (v[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Clamp the incoming value to the largest 8-digit decimal number.
    always_comb begin
        w_sat     = (64'(i_bin) > DEC_MAX);
        w_bin_sat = w_sat ? BIN_WIDTH'(DEC_MAX) : i_bin;
        w_adj     = bcd_adjust(r_bcd);
    end

    // State register.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic and the per-cycle control strobes.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_ack_ok = 1'b0;
        w_tmo    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_CONV;
                end
            end
            S_CONV: begin
                if (r_cnt == '0)
                    w_next = S_WRITE;
            end
            S_WRITE: begin
                if (i_wb_ack) begin
                    w_ack_ok = 1'b1;
                    w_next   = S_IDLE;
                end
`ifdef WB_BCD_TIMEOUT_EN
                else if (r_wait <= TMO_W'(1)) begin
                    w_tmo  = 1'b1;
                    w_next = S_IDLE;
                end
`endif
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Conversion datapath: latch on accept, then shift-add-3 one bit per CONV cycle.
    always_ff @(posedge i_wb_clk) begin
        if (w_accept) begin
            r_bin      <= w_bin_sat;
            r_bcd      <= '0;
            r_cnt      <= CNT_W'(BIN_WIDTH - 1);
            r_ovf_flag <= w_sat;
        end else if (r_state == S_CONV) begin
            r_bcd <= (w_adj << 1) | {31'd0, r_bin[BIN_WIDTH-1]};
            r_bin <= r_bin << 1;
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Completion pulses, raised on the cycle after the write finishes.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            r_done      <= 1'b0;
            r_ovf_pulse <= 1'b0;
        end else begin
            r_done      <= w_ack_ok | w_tmo;
            r_ovf_pulse <= w_ack_ok & r_ovf_flag;
        end
    end

`ifdef WB_BCD_TIMEOUT_EN
    // Ack wait counter and sticky error: loaded when entering WRITE, counts down while no ack.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            r_wait <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == S_CONV && r_cnt == '0)
                r_wait <= TMO_W'(TIMEOUT);
            else if (r_state == S_WRITE && !i_wb_ack && r_wait != '0)
                r_wait <= r_wait - TMO_W'(1);
            if (w_tmo)
                r_err <= 1'b1;
        end
    end
    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign w_wr     = (r_state == S_WRITE);
    assign o_ready  = (r_state == S_IDLE) && !i_wb_rst;
    assign o_wb_adr = WB_ADR;
    assign o_wb_cyc = w_wr;
    assign o_wb_stb = w_wr;
    assign o_wb_we  = w_wr;
    assign o_wb_sel = w_wr ? 4'hF : 4'h0;
    assign o_wb_dat = w_wr ? r_bcd : 32'h0;
    assign o_done   = r_done;
    assign o_ovf    = r_ovf_pulse;

endmodule

// File: tb/tb_wb_bcd_writer.sv
// Directed testbench for wb_bcd_writer: reset state, conversion and write
// timing, saturation, wait states, ack on the first strobe, reset aborts and
// (with WB_BCD_TIMEOUT_EN) the ack timeout.
module tb_wb_bcd_writer;

    localparam int          BW  = 27;
    localparam logic [31:0] ADR = 32'h4000_0010;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] i_bin;
    logic          i_valid;
    logic          o_ready;
    logic [31:0]   o_wb_adr;
    logic [31:0]   o_wb_dat;
    logic [3:0]    o_wb_sel;
    logic          o_wb_we;
    logic          o_wb_cyc;
    logic          o_wb_stb;
    logic          ack;
    logic          o_done;
    logic          o_ovf;
    logic          o_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    wb_bcd_writer #(
        .BIN_WIDTH(BW),
        .WB_ADR   (ADR),
        .TIMEOUT  (8)
    ) dut (
        .i_wb_clk(clk),
        .i_wb_rst(rst),
        .i_bin   (i_bin),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_wb_adr(o_wb_adr),
        .o_wb_dat(o_wb_dat),
        .o_wb_sel(o_wb_sel),
        .o_wb_we (o_wb_we),
        .o_wb_cyc(o_wb_cyc),
        .o_wb_stb(o_wb_stb),
        .i_wb_ack(ack),
        .o_done  (o_done),
        .o_ovf   (o_ovf),
        .o_err   (o_err)
    );

    // Slave model: acks during the strobe cycle that follows 'waits' unacked strobe cycles.
    int scnt = 0;
    int waits = 1;
    bit ack_en = 1'b1;
    assign ack = ack_en && o_wb_cyc && o_wb_stb && (scnt == waits);
    always @(posedge clk) begin
        if (!(o_wb_cyc && o_wb_stb) || ack) scnt <= 0;
        else scnt <= scnt + 1;
    end

    // One transaction; cycle n is counted from the accepting edge (n=1 is the first CONV cycle).
    task automatic do_txn(input logic [BW-1:0] bin, input bit hold,
                          output int first_cyc, output int done_at, output int cyc_n,
                          output logic [31:0] dat, output logic [3:0] sel, output logic we,
                          output logic [31:0] adr, output int done_n, output logic ovf,
                          output bit unstable, output logic rdy_mid, output logic rdy_done);
        int guard;
        first_cyc = -1; done_at = -1; cyc_n = 0; dat = '0; sel = '0; we = 1'b0;
        adr = '0; done_n = 0; ovf = 1'b0; unstable = 1'b0; rdy_mid = 1'b1; rdy_done = 1'b0;
        @(negedge clk);
        guard = 0;
        while (!o_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        i_bin = bin;
        i_valid = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 150; n++) begin
            @(negedge clk);
            if (n == 1) begin
                if (hold) i_bin = BW'(42);
                else i_valid = 1'b0;
            end
            if (o_wb_cyc) begin
                if (first_cyc < 0) begin
                    first_cyc = n; dat = o_wb_dat; sel = o_wb_sel; we = o_wb_we; adr = o_wb_adr;
                end else if (o_wb_dat !== dat || o_wb_sel !== sel || o_wb_we !== we || o_wb_stb !== 1'b1) begin
                    unstable = 1'b1;
                end
                cyc_n++;
            end
            if (n == 5) rdy_mid = o_ready;
            if (o_done) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = n;
                    rdy_done = o_ready;
                end
                ovf = ovf | o_ovf;
                i_valid = 1'b0;
            end
            if (done_at > 0 && n >= done_at + 3) break;
        end
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_bin = '0; ack_en = 1'b1; waits = 1;
        repeat (3) @(negedge clk);
        total_cnt++; if (o_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", o_ready); else pass_cnt++;
        total_cnt++; if ({o_wb_cyc, o_wb_stb, o_wb_we} !== 3'b000) $display("FAIL rst_cyc_stb_we got %b exp 000", {o_wb_cyc, o_wb_stb, o_wb_we}); else pass_cnt++;
        total_cnt++; if (o_wb_sel !== 4'h0) $display("FAIL rst_sel got %h exp 0", o_wb_sel); else pass_cnt++;
        total_cnt++; if (o_wb_dat !== 32'h0) $display("FAIL rst_dat got %h exp 0", o_wb_dat); else pass_cnt++;
        total_cnt++; if ({o_done, o_ovf, o_err} !== 3'b000) $display("FAIL rst_done_ovf_err got %b exp 000", {o_done, o_ovf, o_err}); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (o_ready !== 1'b1) $display("FAIL rst_ready_after got %b exp 1", o_ready); else pass_cnt++;
    endtask

    task automatic test_basic();
        int fc, da, cn, dn; logic [31:0] d, a; logic [3:0] s; logic w, ov, rm, rd; bit us;
        waits = 1;
        do_txn(BW'(12345678), 1'b0, fc, da, cn, d, s, w, a, dn, ov, us, rm, rd);
        total_cnt++; if (d !== 32'h12345678) $display("FAIL basic_dat got %h exp 12345678", d); else pass_cnt++;
        total_cnt++; if (s !== 4'hF || w !== 1'b1) $display("FAIL basic_sel_we got %h/%b exp F/1", s, w); else pass_cnt++;
        total_cnt++; if (a !== ADR) $display("FAIL basic_adr got %h exp %h", a, ADR); else pass_cnt++;
        total_cnt++; if (fc !== 28) $display("FAIL basic_first_cyc got %0d exp 28", fc); else pass_cnt++;
        total_cnt++; if (da !== 30) $display("FAIL basic_done_at got %0d exp 30", da); else pass_cnt++;
        total_cnt++; if (cn !== 2 || dn !== 1) $display("FAIL basic_counts got cyc=%0d done=%0d exp 2/1", cn, dn); else pass_cnt++;
        total_cnt++; if (ov !== 1'b0) $display("FAIL basic_ovf got %b exp 0", ov); else pass_cnt++;
        total_cnt++; if (rm !== 1'b0 || rd !== 1'b1) $display("FAIL basic_ready got mid=%b done=%b exp 0/1", rm, rd); else pass_cnt++;
    endtask

    task automatic test_extremes();
        int fc, da, cn, dn; logic [31:0] d, a; logic [3:0] s; logic w, ov, rm, rd; bit us;
        waits = 1;
        do_txn(BW'(0), 1'b0, fc, da, cn, d, s, w, a, dn, ov, us, rm, rd);
        total_cnt++; if (d !== 32'h0 || da !== 30) $display("FAIL zero_dat got %h at %0d exp 00000000 at 30", d, da); else pass_cnt++;
        do_txn(BW'(99999999), 1'b0, fc, da, cn, d, s, w, a, dn, ov, us, rm, rd);
        total_cnt++; if (d !== 32'h99999999 || ov !== 1'b0) $display("FAIL max_dat got %h ovf=%b exp 99999999 ovf=0", d, ov); else pass_cnt++;
        do_txn(BW'(100000000), 1'b0, fc, da, cn, d, s, w, a, dn, ov, us, rm, rd);
        total_cnt++; if (d !== 32'h99999999) $display("FAIL sat_dat got %h exp 99999999", d); else pass_cnt++;
        total_cnt++; if (ov !== 1'b1 || dn !== 1) $display("FAIL sat_ovf got ovf=%b done=%0d exp 1/1", ov, dn); else pass_cnt++;
    endtask

    task automatic test_wait_states();
        int fc, da, cn, dn, late; logic [31:0] d, a; logic [3:0] s; logic w, ov, rm, rd; bit us;
        waits = 5;
        do_txn(BW'(87654321), 1'b1, fc, da, cn, d, s, w, a, dn, ov, us, rm, rd);
        total_cnt++; if (d !== 32'h87654321) $display("FAIL wait_dat got %h exp 87654321", d); else pass_cnt++;
        total_cnt++; if (cn !== 6 || us !== 1'b0) $display("FAIL wait_cyc got %0d unstable=%b exp 6/0", cn, us); else pass_cnt++;
        total_cnt++; if (da !== 34 || dn !== 1) $display("FAIL wait_done got at=%0d n=%0d exp 34/1", da, dn); else pass_cnt++;
        late = 0;
        repeat (35) begin
            @(negedge clk);
            if (o_wb_cyc || o_done) late++;
        end
        total_cnt++; if (late !== 0) $display("FAIL wait_no_queue got %0d active cycles exp 0", late); else pass_cnt++;
        waits = 0;
        do_txn(BW'(5), 1'b0, fc, da, cn, d, s, w, a, dn, ov, us, rm, rd);
        total_cnt++; if (d !== 32'h5 || cn !== 1 || da !== 29) $display("FAIL ack_first got %h cyc=%0d at=%0d exp 00000005/1/29", d, cn, da); else pass_cnt++;
        waits = 1;
    endtask

    task automatic test_reset_abort();
        int act, guard; logic [31:0] d, a; logic [3:0] s; logic w, ov, rm, rd; bit us;
        int fc, da, cn, dn;
        waits = 1; ack_en = 1'b1;
        @(negedge clk);
        i_bin = BW'(1234); i_valid = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            i_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        total_cnt++; if (o_wb_cyc !== 1'b0 || o_ready !== 1'b0) $display("FAIL conv_rst got cyc=%b ready=%b exp 0/0", o_wb_cyc, o_ready); else pass_cnt++;
        rst = 1'b0;
        act = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_wb_cyc || o_done) act++;
        end
        total_cnt++; if (act !== 0 || o_ready !== 1'b1) $display("FAIL conv_rst_after got act=%0d ready=%b exp 0/1", act, o_ready); else pass_cnt++;
        ack_en = 1'b0;
        i_bin = BW'(4321); i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        guard = 0;
        while (!o_wb_cyc && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total_cnt++; if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0 || guard >= 60) $display("FAIL wr_rst got cyc=%b stb=%b guard=%0d exp 0/0/<60", o_wb_cyc, o_wb_stb, guard); else pass_cnt++;
        rst = 1'b0; ack_en = 1'b1;
        act = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_wb_cyc || o_done) act++;
        end
        total_cnt++; if (act !== 0 || o_ready !== 1'b1) $display("FAIL wr_rst_after got act=%0d ready=%b exp 0/1", act, o_ready); else pass_cnt++;
        do_txn(BW'(2468), 1'b0, fc, da, cn, d, s, w, a, dn, ov, us, rm, rd);
        total_cnt++; if (d !== 32'h2468 || da !== 30) $display("FAIL rst_recover got %h at %0d exp 00002468 at 30", d, da); else pass_cnt++;
    endtask

`ifdef WB_BCD_TIMEOUT_EN
    task automatic test_timeout();
        int fc, da, cn, dn; logic [31:0] d, a; logic [3:0] s; logic w, ov, rm, rd; bit us;
        ack_en = 1'b0;
        do_txn(BW'(100000000), 1'b0, fc, da, cn, d, s, w, a, dn, ov, us, rm, rd);
        total_cnt++; if (cn !== 8 || dn !== 1 || ov !== 1'b0) $display("FAIL tmo got cyc=%0d done=%0d ovf=%b exp 8/1/0", cn, dn, ov); else pass_cnt++;
        total_cnt++; if (o_err !== 1'b1) $display("FAIL tmo_err got %b exp 1", o_err); else pass_cnt++;
        ack_en = 1'b1;
        do_txn(BW'(777), 1'b0, fc, da, cn, d, s, w, a, dn, ov, us, rm, rd);
        total_cnt++; if (d !== 32'h777 || dn !== 1 || o_err !== 1'b1) $display("FAIL tmo_next got %h done=%0d err=%b exp 00000777/1/1", d, dn, o_err); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_wait_states();
        test_reset_abort();
`ifdef WB_BCD_TIMEOUT_EN
        test_timeout();
`else
        total_cnt++; if (o_err !== 1'b0) $display("FAIL err_tied got %b exp 0", o_err); else pass_cnt++;
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
